// File: rtl/disp_pkg.sv
// disp_pkg: shared FSM encoding and BCD constants for the display scan controller
package disp_pkg;
  typedef enum logic {ST_LAMP, ST_SCAN} state_t;
  localparam logic [3:0] BCD_ZERO = 4'd0;
endpackage

// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if: digit data in, multiplexed digit enables and segments out
interface display_scan_ctrl_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] digits_in;
  logic                  load;
  logic                  blank_all;
  logic                  busy;
  logic [N_DIGITS-1:0]   dig_sel_n;
  logic [6:0]            seg;
  modport master (output digits_in, load, blank_all, input busy, dig_sel_n, seg);
  modport slave (input digits_in, load, blank_all, output busy, dig_sel_n, seg);
endinterface

// File: rtl/display_scan_ctrl_dec.sv
// display_scan_ctrl_dec: Standard_7448 BCD-to-7-segment decoder, active-high LT/RBI/BI, seg[0]=a .. seg[6]=g
module display_scan_ctrl_dec
  import disp_pkg::*;
(
  input  logic [3:0] data,
  input  logic       lt,
  input  logic       rbi,
  input  logic       bi,
  output logic [6:0] seg
);
  logic [6:0] glyph;
  always_comb begin
    case (data)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7C;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h67;
      4'd10:   glyph = 7'h58;
      4'd11:   glyph = 7'h4C;
      4'd12:   glyph = 7'h62;
      4'd13:   glyph = 7'h69;
      4'd14:   glyph = 7'h78;
      default: glyph = 7'h00;
    endcase
    seg = bi ? 7'h00 : lt ? 7'h7F : (rbi && data == BCD_ZERO) ? 7'h00 : glyph;
  end
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexes one 7448 decoder over N_DIGITS digits with
// power-on lamp test, leading-zero blanking, anti-ghost gap and frame-aligned updates
module display_scan_ctrl #(
  parameter int N_DIGITS    = 4,
  parameter int SCAN_DIV    = 1000,
  parameter int GAP         = 2,
  parameter int LAMP_CYCLES = 1000
) (
  input logic                clk,
  input logic                rst_n,
  display_scan_ctrl_if.slave bus
);
  import disp_pkg::*;
  localparam int DW = $clog2(SCAN_DIV + 1);
  localparam int LW = $clog2(LAMP_CYCLES + 1);
  localparam int SW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  if (SCAN_DIV <= GAP) begin : g_bad_div
    $error("SCAN_DIV must be greater than GAP");
  end
  if (LAMP_CYCLES < 1) begin : g_bad_lamp
    $error("LAMP_CYCLES must be at least 1");
  end
  state_t                state;
  logic [LW-1:0]         lamp_cnt;
  logic [DW-1:0]         div_cnt;
  logic [SW-1:0]         slot;
  logic [N_DIGITS-1:0][3:0] shadow;
  logic [N_DIGITS-1:0][3:0] active;
  logic [N_DIGITS:0]     nz;
  logic [N_DIGITS-1:0]   lz;
  logic                  drv_lt;
  logic                  drv_rbi;
  logic                  drv_bi;
  logic [3:0]            drv_data;
  logic                  lamp_done;
  logic                  div_wrap;
  logic                  slot_wrap;
  // nz[i]: some active digit at position i or above is non-zero
  assign nz[N_DIGITS] = 1'b0;
  for (genvar i = 0; i < N_DIGITS; i++) begin : g_lz
    assign nz[i] = nz[i+1] | (active[i] != BCD_ZERO);
    assign lz[i] = ~nz[i];
  end
  assign lamp_done = lamp_cnt == LW'(LAMP_CYCLES - 1);
  assign div_wrap  = div_cnt == DW'(SCAN_DIV - 1);
  assign slot_wrap = slot == SW'(N_DIGITS - 1);
  // Outputs are registered from the current scan position so enables and decoder inputs switch together
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= ST_LAMP;
      lamp_cnt      <= '0;
      div_cnt       <= '0;
      slot          <= '0;
      shadow        <= '0;
      active        <= '0;
      drv_lt        <= 1'b0;
      drv_rbi       <= 1'b0;
      drv_bi        <= 1'b1;
      drv_data      <= BCD_ZERO;
      bus.busy      <= 1'b1;
      bus.dig_sel_n <= '1;
    end else begin
      if (bus.load) shadow <= bus.digits_in;
      bus.busy      <= state == ST_LAMP;
      bus.dig_sel_n <= state == ST_LAMP ? '0 : ~(N_DIGITS'(1) << slot);
      drv_lt        <= state == ST_LAMP;
      drv_bi        <= state == ST_SCAN && (div_cnt < DW'(GAP) || bus.blank_all);
      drv_rbi       <= state == ST_SCAN && slot != '0 && lz[slot];
      drv_data      <= state == ST_LAMP ? BCD_ZERO : active[slot];
      if (state == ST_LAMP) begin
        lamp_cnt <= lamp_done ? '0 : lamp_cnt + 1'b1;
        if (lamp_done) begin
          state   <= ST_SCAN;
          div_cnt <= '0;
          slot    <= '0;
          active  <= shadow;
        end
      end else begin
        div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
        if (div_wrap) slot <= slot_wrap ? '0 : slot + 1'b1;
        if (div_wrap && slot_wrap) active <= shadow;
      end
    end
  display_scan_ctrl_dec u_dec (
    .data (drv_data),
    .lt   (drv_lt),
    .rbi  (drv_rbi),
    .bi   (drv_bi),
    .seg  (bus.seg)
  );
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed scoreboard bench; expected outputs per cycle are queued from a frame-level model
module tb_display_scan_ctrl;
  typedef struct packed {
    logic [3:0] dig;
    logic [6:0] seg;
    logic       busy;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  exp_t sb[$];
  string phase = "reset";
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7C, 7'h07,
                             7'h7F, 7'h67, 7'h58, 7'h4C, 7'h62, 7'h69, 7'h78, 7'h00};
  int m_lamp;
  int m_pos;
  logic [15:0] m_shadow;
  logic [15:0] m_pend;
  logic [15:0] m_active;
  display_scan_ctrl_if #(.N_DIGITS(4)) bus ();
  display_scan_ctrl #(.N_DIGITS(4), .SCAN_DIV(4), .GAP(1), .LAMP_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  function automatic exp_t scan_exp(int p);
    int s = p / 4;
    int d = p % 4;
    logic [3:0] v;
    logic lz;
    exp_t e;
    v = m_active[4*s +: 4];
    lz = s != 0;
    for (int i = s; i < 4; i++) if (m_active[4*i +: 4] != 4'd0) lz = 1'b0;
    e.dig = ~(4'b0001 << s);
    e.busy = 1'b0;
    e.seg = (d < 1 || bus.blank_all || lz) ? 7'h00 : glyph[v];
    return e;
  endfunction
  task automatic check();
    exp_t e;
    e = sb.pop_front();
    n_chk++;
    assert (bus.dig_sel_n === e.dig) else begin
      n_fail++;
      $error("FAIL %s dig_sel_n got %b exp %b", phase, bus.dig_sel_n, e.dig);
    end
    n_chk++;
    assert (bus.seg === e.seg) else begin
      n_fail++;
      $error("FAIL %s seg got %h exp %h", phase, bus.seg, e.seg);
    end
    n_chk++;
    assert (bus.busy === e.busy) else begin
      n_fail++;
      $error("FAIL %s busy got %b exp %b", phase, bus.busy, e.busy);
    end
  endtask
  task automatic model_reset();
    m_lamp = 0;
    m_pos = 15;
    m_shadow = '0;
    m_pend = '0;
    m_active = '0;
  endtask
  task automatic expect_reset();
    sb.push_back('{4'b1111, 7'h00, 1'b1});
    check();
  endtask
  task automatic tick();
    exp_t e;
    if (m_lamp < 8) begin
      m_lamp++;
      if (m_lamp == 8) m_pend = m_shadow;
      e = '{4'b0000, 7'h7F, 1'b1};
    end else begin
      m_pos = (m_pos + 1) % 16;
      if (m_pos == 0) m_active = m_pend;
      if (m_pos == 15) m_pend = m_shadow;
      e = scan_exp(m_pos);
    end
    if (bus.load) m_shadow = bus.digits_in;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check();
  endtask
  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic load_tick(logic [15:0] v);
    bus.digits_in = v;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask
  initial begin
    bus.digits_in = '0;
    bus.load = 1'b0;
    bus.blank_all = 1'b0;
    model_reset();
    @(negedge clk);
    expect_reset();
    rst_n = 1'b1;
    phase = "lamp";
    run(8);
    phase = "first_scan";
    run(16);
    phase = "load_0123";
    while (m_pos != 0) tick();
    load_tick(16'h0123);
    run(32);
    phase = "load_0000";
    load_tick(16'h0000);
    run(32);
    phase = "load_1000";
    load_tick(16'h1000);
    run(32);
    phase = "load_hex";
    load_tick(16'hFEDC);
    run(32);
    phase = "mid_frame_load";
    while (m_pos != 8) tick();
    load_tick(16'h0456);
    run(32);
    phase = "boundary_load";
    while (m_pos != 14) tick();
    load_tick(16'h0789);
    run(32);
    phase = "blank_all";
    bus.blank_all = 1'b1;
    run(20);
    phase = "unblank";
    bus.blank_all = 1'b0;
    run(20);
    phase = "async_reset";
    while (m_pos != 5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    expect_reset();
    @(negedge clk);
    expect_reset();
    model_reset();
    rst_n = 1'b1;
    phase = "lamp_again";
    run(8);
    phase = "scan_after_reset";
    run(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
